// File: rtl/ascon_sequencer.sv
// Ascon permutation sequencer: decodes SPI operation triggers into state-register update selects.
// Optional macro ASCON_DEBUG_PERM_EN enables the bare-permutation debug mode (100).
module ascon_sequencer #(
    parameter int unsigned PA_ROUNDS = 12,
    parameter int unsigned PB_ROUNDS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       operation_ready,
    input  logic [2:0] operation_mode,
    output logic [2:0] state_sel,
    output logic       state_we,
    output logic [3:0] round_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ROUND,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [2:0] MODE_INIT    = 3'b001;
    localparam logic [2:0] MODE_PROCESS = 3'b010;
    localparam logic [2:0] MODE_FINAL   = 3'b011;
`ifdef ASCON_DEBUG_PERM_EN
    localparam logic [2:0] MODE_PERM    = 3'b100;
`endif

    localparam logic [2:0] SEL_HOLD     = 3'd0;
    localparam logic [2:0] SEL_LOAD_IV  = 3'd1;
    localparam logic [2:0] SEL_XOR_DATA = 3'd2;
    localparam logic [2:0] SEL_XOR_PRE  = 3'd3;
    localparam logic [2:0] SEL_XOR_POST = 3'd4;
    localparam logic [2:0] SEL_ROUND    = 3'd5;

    // Round constants always end at index 11, so fewer rounds start later.
    localparam logic [3:0] PA_START = 4'(12 - PA_ROUNDS);
    localparam logic [3:0] PB_START = 4'(12 - PB_ROUNDS);
    localparam logic [3:0] LAST_IDX = 4'd11;

    state_t     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ready_q;
    logic       trigger;
    logic       mode_legal;
    logic       err_d;
    logic [2:0] sel_d;
    logic       we_d;
    logic [3:0] idx_d;
    logic       busy_d;
    logic       done_d;

    assign trigger = operation_ready & ~ready_q;

    always_comb begin
        mode_legal = 1'b0;
        case (operation_mode)
            MODE_INIT, MODE_PROCESS, MODE_FINAL: mode_legal = 1'b1;
`ifdef ASCON_DEBUG_PERM_EN
            MODE_PERM: mode_legal = 1'b1;
`endif
            default: mode_legal = 1'b0;
        endcase
    end

    // Next-state logic plus output decode of the next state, so outputs register alongside the state.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    if (mode_legal) begin
                        mode_d  = operation_mode;
                        state_d = S_PREP;
`ifdef ASCON_DEBUG_PERM_EN
                        if (operation_mode == MODE_PERM) begin
                            state_d = S_ROUND;
                            cnt_d   = PA_START;
                        end
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PREP: begin
                state_d = S_ROUND;
                cnt_d   = (mode_q == MODE_PROCESS) ? PB_START : PA_START;
            end
            S_ROUND: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = 4'd0;
                    state_d = (mode_q == MODE_PROCESS) ? S_DONE : S_POST;
`ifdef ASCON_DEBUG_PERM_EN
                    if (mode_q == MODE_PERM) begin
                        state_d = S_DONE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_POST:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        sel_d  = SEL_HOLD;
        we_d   = 1'b0;
        idx_d  = 4'd0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_PREP: begin
                we_d   = 1'b1;
                busy_d = 1'b1;
                case (mode_d)
                    MODE_INIT:    sel_d = SEL_LOAD_IV;
                    MODE_PROCESS: sel_d = SEL_XOR_DATA;
                    default:      sel_d = SEL_XOR_PRE;
                endcase
            end
            S_ROUND: begin
                we_d   = 1'b1;
                busy_d = 1'b1;
                sel_d  = SEL_ROUND;
                idx_d  = cnt_d;
            end
            S_POST: begin
                we_d   = 1'b1;
                busy_d = 1'b1;
                sel_d  = SEL_XOR_POST;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 3'd0;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b0;
            state_sel <= SEL_HOLD;
            state_we  <= 1'b0;
            round_idx <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            ready_q   <= operation_ready;
            state_sel <= sel_d;
            state_we  <= we_d;
            round_idx <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule
